// File: rtl/operand_fetch.sv
// Register-read stage: 16x32 register file, immediate extension and a 1-entry elastic output register (1-cycle latency).
// Backpressure: inReady drops on a full stalled output, hazard/HOLD or flush. Define OPERAND_FETCH_WB_BYPASS_EN for writeback bypass.
module operand_fetch #(
    parameter int NREGS = 16,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            clrN,
    input  logic            inValid,
    output logic            inReady,
    input  logic [4:0]      opcode,
    input  logic            iOrReg,
    input  logic [3:0]      rd,
    input  logic [3:0]      rs1,
    input  logic [3:0]      rs2,
    input  logic [1:0]      modifier,
    input  logic [15:0]     imm,
    input  logic            flush,
    input  logic            wbEn,
    input  logic [3:0]      wbAddr,
    input  logic [XLEN-1:0] wbData,
    output logic            outValid,
    input  logic            outReady,
    output logic [4:0]      opcodeOut,
    output logic [3:0]      rdOut,
    output logic            isImmOut,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] storeData
);

    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {RUN, HOLD} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_rf [NREGS];

    logic            r_vld;
    logic [4:0]      r_opc;
    logic [3:0]      r_rd;
    logic            r_isimm;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_sd;

    logic            w_no_src;
    logic            w_is_st;
    logic [3:0]      w_src1;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_rd_val;
    logic [XLEN-1:0] w_imm_ext;
    logic            w_match;
    logic            w_hazard;
    logic            w_load;

    assign w_no_src = (opcode == OP_NOP) || (opcode == OP_BEQ) || (opcode == OP_BGT) ||
                      (opcode == OP_B)   || (opcode == OP_CALL);
    assign w_is_st  = (opcode == OP_ST);
    assign w_src1   = (opcode == OP_RET) ? 4'd15 : rs1;

    assign w_rs1_val = (BYPASS && wbEn && wbAddr == w_src1) ? wbData : r_rf[w_src1];
    assign w_rs2_val = (BYPASS && wbEn && wbAddr == rs2)    ? wbData : r_rf[rs2];
    assign w_rd_val  = (BYPASS && wbEn && wbAddr == rd)     ? wbData : r_rf[rd];

    always_comb begin
        case (modifier)
            2'b01:   w_imm_ext = XLEN'(imm);
            2'b10:   w_imm_ext = XLEN'({imm, 16'h0000});
            default: w_imm_ext = XLEN'($signed(imm));
        endcase
    end

    // Only registers this opcode really reads can collide with the pending write.
    assign w_match  = wbEn && !w_no_src &&
                      ((wbAddr == w_src1) || (!iOrReg && wbAddr == rs2) || (w_is_st && wbAddr == rd));
    assign w_hazard = !BYPASS && inValid && w_match;

    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) r_state <= RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN:     if (w_hazard) w_state_nxt = HOLD;
                HOLD:    w_state_nxt = RUN;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        inReady = (!r_vld || outReady) && (r_state == RUN) && !w_hazard && !flush;
    end

    assign w_load = inValid && inReady;

    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (wbEn) begin
            r_rf[wbAddr] <= wbData;
        end
    end

    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            r_vld   <= 1'b0;
            r_opc   <= '0;
            r_rd    <= '0;
            r_isimm <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_sd    <= '0;
        end else if (flush) begin
            r_vld <= 1'b0;
        end else if (w_load) begin
            r_vld   <= 1'b1;
            r_opc   <= opcode;
            r_rd    <= rd;
            r_isimm <= iOrReg;
            r_op1   <= w_no_src ? '0 : w_rs1_val;
            r_op2   <= w_no_src ? '0 : (iOrReg ? w_imm_ext : w_rs2_val);
            r_sd    <= w_is_st ? w_rd_val : '0;
        end else if (outReady) begin
            r_vld <= 1'b0;
        end
    end

    assign outValid  = r_vld;
    assign opcodeOut = r_opc;
    assign rdOut     = r_rd;
    assign isImmOut  = r_isimm;
    assign op1       = r_op1;
    assign op2       = r_op2;
    assign storeData = r_sd;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus randomized traffic against a behavioural model.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clrN;
    logic        inValid;
    logic        inReady;
    logic [4:0]  opcode;
    logic        iOrReg;
    logic [3:0]  rd, rs1, rs2;
    logic [1:0]  modifier;
    logic [15:0] imm;
    logic        flush;
    logic        wbEn;
    logic [3:0]  wbAddr;
    logic [31:0] wbData;
    logic        outValid;
    logic        outReady;
    logic [4:0]  opcodeOut;
    logic [3:0]  rdOut;
    logic        isImmOut;
    logic [31:0] op1, op2, storeData;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .clrN(clrN), .inValid(inValid), .inReady(inReady),
        .opcode(opcode), .iOrReg(iOrReg), .rd(rd), .rs1(rs1), .rs2(rs2),
        .modifier(modifier), .imm(imm), .flush(flush),
        .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
        .outValid(outValid), .outReady(outReady), .opcodeOut(opcodeOut),
        .rdOut(rdOut), .isImmOut(isImmOut), .op1(op1), .op2(op2), .storeData(storeData)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: architectural register contents, output slot and "stalled last cycle" flag.
    logic [31:0] mrf [16];
    bit          m_vld;
    bit          m_hold;
    logic [4:0]  e_opc;
    logic [3:0]  e_rd;
    logic        e_imm;
    logic [31:0] e_op1, e_op2, e_sd;

    function automatic logic [31:0] ext_imm(input logic [1:0] m, input logic [15:0] v);
        case (m)
            2'b01:   return {16'h0000, v};
            2'b10:   return {v, 16'h0000};
            default: return {{16{v[15]}}, v};
        endcase
    endfunction

    function automatic logic [31:0] reg_val(input logic [3:0] a);
        if (BYP && wbEn && wbAddr == a) return wbData;
        return mrf[a];
    endfunction

    function automatic bit reads_nothing();
        return opcode inside {5'd13, 5'd16, 5'd17, 5'd18, 5'd19};
    endfunction

    function automatic logic [3:0] first_src();
        return (opcode == 5'd20) ? 4'd15 : rs1;
    endfunction

    function automatic bit reads_reg(input logic [3:0] a);
        if (reads_nothing()) return 1'b0;
        return (a == first_src()) || (!iOrReg && a == rs2) || (opcode == 5'd15 && a == rd);
    endfunction

    function automatic bit hazard_now();
        return !BYP && inValid && wbEn && reads_reg(wbAddr);
    endfunction

    function automatic bit exp_ready();
        return (!m_vld || outReady) && !m_hold && !hazard_now() && !flush;
    endfunction

    task automatic idle();
        inValid = 0; wbEn = 0; flush = 0; outReady = 1;
    endtask

    task automatic model_reset();
        foreach (mrf[i]) mrf[i] = '0;
        m_vld = 0; m_hold = 0;
        e_opc = '0; e_rd = '0; e_imm = 0; e_op1 = '0; e_op2 = '0; e_sd = '0;
    endtask

    task automatic set_instr(input logic [4:0] o, input logic i, input logic [3:0] d,
                             input logic [3:0] s1, input logic [3:0] s2,
                             input logic [1:0] m, input logic [15:0] v);
        inValid = 1; opcode = o; iOrReg = i; rd = d; rs1 = s1; rs2 = s2; modifier = m; imm = v;
    endtask

    // Advances one clock edge and moves the model along with it.
    task automatic step();
        bit haz, acc;
        logic [31:0] n1, n2, ns;
        haz = hazard_now();
        acc = inValid && exp_ready();
        n1 = reads_nothing() ? 32'h0 : reg_val(first_src());
        n2 = reads_nothing() ? 32'h0 : (iOrReg ? ext_imm(modifier, imm) : reg_val(rs2));
        ns = (opcode == 5'd15) ? reg_val(rd) : 32'h0;
        @(posedge clk);
        if (flush) m_vld = 0;
        else if (acc) begin
            m_vld = 1; e_opc = opcode; e_rd = rd; e_imm = iOrReg;
            e_op1 = n1; e_op2 = n2; e_sd = ns;
        end else if (outReady) m_vld = 0;
        m_hold = !flush && !m_hold && haz;
        if (wbEn) mrf[wbAddr] = wbData;
        #1;
    endtask

    task automatic test_reset();
        clrN = 0; idle(); set_instr(0, 0, 0, 0, 0, 0, 0); inValid = 0;
        wbAddr = 0; wbData = 0; model_reset();
        #12;
        checks++;
        if ({outValid, opcodeOut, rdOut, isImmOut, op1, op2, storeData} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got vld=%b op1=%h op2=%h sd=%h opc=%h rd=%h imm=%b required all 0",
                     outValid, op1, op2, storeData, opcodeOut, rdOut, isImmOut);
        end
        clrN = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        wbEn = 1; wbAddr = 1; wbData = 32'd5;
        step();
        wbEn = 0;
        set_instr(5'd1, 0, 4'd2, 4'd1, 4'd1, 2'b00, 16'h0);
        #1;
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("FAIL add_inready got %b required 1", inReady); end
        step();
        inValid = 0;
        checks++;
        if (outValid !== 1'b1 || op1 !== 32'd5 || op2 !== 32'd5 || rdOut !== 4'd2) begin
            errors++;
            $display("FAIL add_out got vld=%b op1=%h op2=%h rd=%h required 1/5/5/2", outValid, op1, op2, rdOut);
        end
        step();
        checks++;
        if (outValid !== 1'b0) begin errors++; $display("FAIL add_drain got vld=%b required 0", outValid); end
    endtask

    task automatic test_imm_ext();
        logic [31:0] tbl [4];
        tbl[0] = 32'hFFFFFFFE; tbl[1] = 32'h0000FFFE; tbl[2] = 32'hFFFE0000; tbl[3] = 32'hFFFFFFFE;
        for (int m = 0; m < 4; m++) begin
            set_instr(5'd2, 1, 4'd1, 4'd0, 4'd0, 2'(m), 16'hFFFE);
            step();
            checks++;
            if (outValid !== 1'b1 || op2 !== tbl[m] || isImmOut !== 1'b1) begin
                errors++;
                $display("FAIL imm_ext_mod%0d got vld=%b op2=%h required 1/%h", m, outValid, op2, tbl[m]);
            end
        end
        inValid = 0;
        step();
    endtask

    task automatic test_wb_hazard();
        wbEn = 1; wbAddr = 3; wbData = 32'd9;
        set_instr(5'd1, 0, 4'd6, 4'd3, 4'd0, 2'b00, 16'h0);
        #1;
        checks++;
        if (inReady !== BYP) begin errors++; $display("FAIL hazard_detect_inready got %b required %b", inReady, BYP); end
        step();
        wbEn = 0;
        if (!BYP) begin
            #1;
            checks++;
            if (inReady !== 1'b0) begin errors++; $display("FAIL hazard_hold_inready got %b required 0", inReady); end
            step();
            #1;
            checks++;
            if (inReady !== 1'b1) begin errors++; $display("FAIL hazard_release_inready got %b required 1", inReady); end
            step();
        end
        inValid = 0;
        checks++;
        if (outValid !== 1'b1 || op1 !== 32'd9 || rdOut !== 4'd6) begin
            errors++;
            $display("FAIL hazard_op1 got vld=%b op1=%h rd=%h required 1/9/6", outValid, op1, rdOut);
        end
        step();
    endtask

    task automatic test_backpressure();
        set_instr(5'd1, 1, 4'd7, 4'd1, 4'd0, 2'b01, 16'h1234);
        step();
        outReady = 0;
        set_instr(5'd3, 1, 4'd8, 4'd1, 4'd0, 2'b01, 16'h0077);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (inReady !== 1'b0) begin errors++; $display("FAIL bp_inready_c%0d got %b required 0", c, inReady); end
            step();
            checks++;
            if (outValid !== 1'b1 || rdOut !== 4'd7 || op1 !== 32'd5 || op2 !== 32'h1234 || opcodeOut !== 5'd1) begin
                errors++;
                $display("FAIL bp_hold_c%0d got vld=%b rd=%h op1=%h op2=%h required 1/7/5/1234", c, outValid, rdOut, op1, op2);
            end
        end
        outReady = 1;
        #1;
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("FAIL bp_release_inready got %b required 1", inReady); end
        step();
        inValid = 0;
        checks++;
        if (outValid !== 1'b1 || rdOut !== 4'd8 || op2 !== 32'h77 || opcodeOut !== 5'd3) begin
            errors++;
            $display("FAIL bp_pending got vld=%b rd=%h op2=%h opc=%h required 1/8/77/3", outValid, rdOut, op2, opcodeOut);
        end
    endtask

    task automatic test_flush();
        set_instr(5'd4, 0, 4'd9, 4'd1, 4'd1, 2'b00, 16'h0);
        flush = 1;
        #1;
        checks++;
        if (inReady !== 1'b0) begin errors++; $display("FAIL flush_inready got %b required 0", inReady); end
        step();
        flush = 0; inValid = 0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (outValid !== 1'b0) begin errors++; $display("FAIL flush_vld_c%0d got %b required 0", c, outValid); end
            step();
        end
    endtask

    task automatic test_store_reset();
        wbEn = 1; wbAddr = 4; wbData = 32'hAA; step();
        wbAddr = 5; wbData = 32'h100; step();
        wbEn = 0;
        set_instr(5'd15, 1, 4'd4, 4'd5, 4'd0, 2'b00, 16'h0008);
        step();
        checks++;
        if (storeData !== 32'hAA || op1 !== 32'h100 || op2 !== 32'h8 || opcodeOut !== 5'd15) begin
            errors++;
            $display("FAIL st_fields got sd=%h op1=%h op2=%h opc=%h required AA/100/8/15", storeData, op1, op2, opcodeOut);
        end
        outReady = 0;
        set_instr(5'd1, 0, 4'd1, 4'd1, 4'd1, 2'b00, 16'h0);
        step();
        #2 clrN = 0;
        #1;
        checks++;
        if ({outValid, opcodeOut, rdOut, isImmOut, op1, op2, storeData} !== '0) begin
            errors++;
            $display("FAIL midstall_reset got vld=%b op1=%h op2=%h sd=%h opc=%h required all 0",
                     outValid, op1, op2, storeData, opcodeOut);
        end
        #2 clrN = 1;
        model_reset(); idle();
        @(posedge clk); #1;
        set_instr(5'd1, 0, 4'd2, 4'd4, 4'd5, 2'b00, 16'h0);
        step();
        inValid = 0;
        checks++;
        if (outValid !== 1'b1 || op1 !== 32'h0 || op2 !== 32'h0) begin
            errors++;
            $display("FAIL rf_cleared got vld=%b op1=%h op2=%h required 1/0/0", outValid, op1, op2);
        end
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            inValid  = ($urandom_range(0, 3) != 0);
            opcode   = 5'($urandom_range(0, 31));
            iOrReg   = 1'($urandom_range(0, 1));
            rd       = 4'($urandom_range(0, 15));
            rs1      = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            rs2      = 4'($urandom_range(0, 3));
            modifier = 2'($urandom_range(0, 3));
            imm      = 16'($urandom);
            wbEn     = ($urandom_range(0, 1) != 0);
            wbAddr   = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            wbData   = $urandom;
            outReady = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            #1;
            checks++;
            if (inReady !== exp_ready()) begin
                errors++;
                $display("FAIL rand_inready_%0d got %b required %b", n, inReady, exp_ready());
            end
            step();
            checks++;
            if (outValid !== m_vld) begin
                errors++;
                $display("FAIL rand_vld_%0d got %b required %b", n, outValid, m_vld);
            end else if (m_vld && {opcodeOut, rdOut, isImmOut, op1, op2, storeData} !==
                                  {e_opc, e_rd, e_imm, e_op1, e_op2, e_sd}) begin
                errors++;
                $display("FAIL rand_fields_%0d got opc=%h rd=%h imm=%b op1=%h op2=%h sd=%h required %h/%h/%b/%h/%h/%h",
                         n, opcodeOut, rdOut, isImmOut, op1, op2, storeData, e_opc, e_rd, e_imm, e_op1, e_op2, e_sd);
            end
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm_ext();
        test_wb_hazard();
        test_backpressure();
        test_flush();
        test_store_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
